// File: rtl/sram_sched_pkg.sv
// Shared widths, FSM state encoding and SRAM region helpers for sram_track_scheduler.
package sram_sched_pkg;

    localparam int NUM_TRACKS  = 4;
    localparam int ADDR_W      = 20;
    localparam int DATA_W      = 16;
    localparam int TRACK_SHIFT = 17;
    localparam int TRACK_LEN   = 1 << TRACK_SHIFT;
    localparam int OFF_W       = $clog2(TRACK_LEN);
    localparam int IDX_W       = $clog2(NUM_TRACKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_CAPT,
        S_WR_SET,
        S_WR_PLS,
        S_DONE
    } state_t;

    // Track t lives one region above the record region at address 0.
    function automatic logic [ADDR_W-1:0] track_base(input logic [IDX_W-1:0] t);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(t) + ADDR_W'(1);
        return r << TRACK_SHIFT;
    endfunction

endpackage

// File: rtl/sram_port.sv
// SRAM pin register stage: registered ADDR/WE_N/OE_N, DQ tristate driver and per-track capture bank.
module sram_port
    import sram_sched_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [ADDR_W-1:0]            i_addr_nxt,
    input  logic                         i_we_n_nxt,
    input  logic                         i_oe_n_nxt,
    input  logic                         i_dq_oe_nxt,
    input  logic                         i_wr_load,
    input  logic [DATA_W-1:0]            i_wr_data,
    input  logic                         i_capt,
    input  logic [IDX_W-1:0]             i_capt_idx,
    output logic [NUM_TRACKS*DATA_W-1:0] o_shadow,
    output logic [ADDR_W-1:0]            o_SRAM_ADDR,
    output logic                         o_SRAM_WE_N,
    output logic                         o_SRAM_OE_N,
    inout  wire  [DATA_W-1:0]            io_SRAM_DQ
);

    logic              r_dq_oe;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_shadow [NUM_TRACKS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_SRAM_ADDR <= '0;
            o_SRAM_WE_N <= 1'b1;
            o_SRAM_OE_N <= 1'b0;
            r_dq_oe     <= 1'b0;
            r_wr_data   <= '0;
            for (int t = 0; t < NUM_TRACKS; t++) r_shadow[t] <= '0;
        end else begin
            o_SRAM_ADDR <= i_addr_nxt;
            o_SRAM_WE_N <= i_we_n_nxt;
            o_SRAM_OE_N <= i_oe_n_nxt;
            r_dq_oe     <= i_dq_oe_nxt;
            if (i_wr_load) r_wr_data <= i_wr_data;
            if (i_capt) r_shadow[i_capt_idx] <= io_SRAM_DQ;
        end
    end

    always_comb begin
        o_shadow = '0;
        for (int t = 0; t < NUM_TRACKS; t++) o_shadow[t*DATA_W +: DATA_W] = r_shadow[t];
    end

    assign io_SRAM_DQ = r_dq_oe ? r_wr_data : 'z;

endmodule

// File: rtl/sram_track_scheduler.sv
// Shares one async SRAM between NUM_TRACKS playback reads and one record write per sample tick.
// Build with RECORD_EN defined to include the record-write slot.
//   state     | meaning
//   S_IDLE    | waiting for i_sample_tick
//   S_RD_ADDR | track address on pins
//   S_RD_CAPT | capture DQ into track shadow
//   S_WR_SET  | record address/data set up, WE_N high
//   S_WR_PLS  | WE_N low, write committed
//   S_DONE    | publish samples, advance offset
module sram_track_scheduler
    import sram_sched_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_sample_tick,
    input  logic [NUM_TRACKS-1:0]        i_track_en,
    input  logic                         i_restart,
    input  logic                         i_wr_req,
    input  logic [DATA_W-1:0]            i_wr_data,
    output logic                         o_wr_ack,
    output logic [NUM_TRACKS*DATA_W-1:0] o_samples,
    output logic                         o_sample_valid,
    output logic [OFF_W-1:0]             o_offset,
    output logic                         o_wrap,
    output logic                         o_overrun,
    output logic                         o_busy,
    output logic [ADDR_W-1:0]            o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0]            io_SRAM_DQ,
    output logic                         o_SRAM_WE_N,
    output logic                         o_SRAM_CE_N,
    output logic                         o_SRAM_OE_N,
    output logic                         o_SRAM_LB_N,
    output logic                         o_SRAM_UB_N
);

    state_t                        r_state, w_state_nxt, w_chk_state;
    logic [IDX_W-1:0]              r_idx, w_idx_nxt, w_first_idx, w_next_idx;
    logic                          w_any_en, w_has_next, w_capt, w_wr_load;
    logic [NUM_TRACKS-1:0]         r_en;
    logic [OFF_W-1:0]              r_offset, w_off_rd;
    logic                          r_restart_pend;
    logic [NUM_TRACKS*DATA_W-1:0]  r_samples, w_shadow, w_masked;
    logic                          r_valid, r_wrap, r_overrun;
    logic [ADDR_W-1:0]             w_addr_nxt;
    logic                          w_we_n_nxt, w_oe_n_nxt, w_dq_oe_nxt;

`ifdef RECORD_EN
    assign w_chk_state = i_wr_req ? S_WR_SET : S_DONE;
    assign o_wr_ack    = (r_state == S_WR_PLS);
`else
    assign w_chk_state = S_DONE;
    assign o_wr_ack    = 1'b0;
    wire   w_unused_wr_req = i_wr_req;
`endif

    // A restart coinciding with the tick applies to the reads of that same tick.
    assign w_off_rd = (r_state == S_IDLE && i_restart) ? '0 : r_offset;

    always_comb begin
        w_any_en    = 1'b0;
        w_first_idx = '0;
        w_has_next  = 1'b0;
        w_next_idx  = r_idx;
        for (int t = NUM_TRACKS-1; t >= 0; t--) begin
            if (i_track_en[t]) begin
                w_any_en    = 1'b1;
                w_first_idx = IDX_W'(t);
            end
            if (r_en[t] && IDX_W'(t) > r_idx) begin
                w_has_next = 1'b1;
                w_next_idx = IDX_W'(t);
            end
        end

        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capt      = 1'b0;
        case (r_state)
            S_IDLE: if (i_sample_tick) begin
                w_state_nxt = w_any_en ? S_RD_ADDR : w_chk_state;
                w_idx_nxt   = w_first_idx;
            end
            S_RD_ADDR: w_state_nxt = S_RD_CAPT;
            S_RD_CAPT: begin
                w_capt = 1'b1;
                if (w_has_next) begin
                    w_state_nxt = S_RD_ADDR;
                    w_idx_nxt   = w_next_idx;
                end else begin
                    w_state_nxt = w_chk_state;
                end
            end
`ifdef RECORD_EN
            S_WR_SET: w_state_nxt = S_WR_PLS;
            S_WR_PLS: w_state_nxt = S_DONE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase

        // Pin values for the coming cycle, so the pins always match the current state.
        w_addr_nxt  = o_SRAM_ADDR;
        w_we_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b0;
        w_dq_oe_nxt = 1'b0;
        case (w_state_nxt)
            S_RD_ADDR: w_addr_nxt = track_base(w_idx_nxt) | ADDR_W'(w_off_rd);
`ifdef RECORD_EN
            S_WR_SET: begin
                w_addr_nxt  = ADDR_W'(r_offset);
                w_oe_n_nxt  = 1'b1;
                w_dq_oe_nxt = 1'b1;
            end
            S_WR_PLS: begin
                w_addr_nxt  = ADDR_W'(r_offset);
                w_oe_n_nxt  = 1'b1;
                w_we_n_nxt  = 1'b0;
                w_dq_oe_nxt = 1'b1;
            end
`endif
            default: ;
        endcase

        w_masked = '0;
        for (int t = 0; t < NUM_TRACKS; t++)
            if (r_en[t]) w_masked[t*DATA_W +: DATA_W] = w_shadow[t*DATA_W +: DATA_W];
    end

    assign w_wr_load = (w_state_nxt == S_WR_SET);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_en           <= '0;
            r_offset       <= '0;
            r_restart_pend <= 1'b0;
            r_samples      <= '0;
            r_valid        <= 1'b0;
            r_wrap         <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= 1'b0;
            r_wrap    <= 1'b0;
            r_overrun <= i_sample_tick && (r_state != S_IDLE);
            if (r_state == S_IDLE) begin
                r_restart_pend <= 1'b0;
                if (i_sample_tick) r_en <= i_track_en;
                if (i_restart) r_offset <= '0;
            end else if (r_state == S_DONE) begin
                r_valid        <= 1'b1;
                r_samples      <= w_masked;
                r_restart_pend <= 1'b0;
                if (r_restart_pend || i_restart) begin
                    r_offset <= '0;
                end else if (r_offset == OFF_W'(TRACK_LEN-1)) begin
                    r_offset <= '0;
                    r_wrap   <= 1'b1;
                end else begin
                    r_offset <= r_offset + 1'b1;
                end
            end else if (i_restart) begin
                r_restart_pend <= 1'b1;
            end
        end
    end

    sram_port u_port (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_addr_nxt  (w_addr_nxt),
        .i_we_n_nxt  (w_we_n_nxt),
        .i_oe_n_nxt  (w_oe_n_nxt),
        .i_dq_oe_nxt (w_dq_oe_nxt),
        .i_wr_load   (w_wr_load),
        .i_wr_data   (i_wr_data),
        .i_capt      (w_capt),
        .i_capt_idx  (r_idx),
        .o_shadow    (w_shadow),
        .o_SRAM_ADDR (o_SRAM_ADDR),
        .o_SRAM_WE_N (o_SRAM_WE_N),
        .o_SRAM_OE_N (o_SRAM_OE_N),
        .io_SRAM_DQ  (io_SRAM_DQ)
    );

    assign o_samples      = r_samples;
    assign o_sample_valid = r_valid;
    assign o_offset       = r_offset;
    assign o_wrap         = r_wrap;
    assign o_overrun      = r_overrun;
    assign o_busy         = (r_state != S_IDLE);
    assign o_SRAM_CE_N    = 1'b0;
    assign o_SRAM_LB_N    = 1'b0;
    assign o_SRAM_UB_N    = 1'b0;

endmodule

// File: tb/tb_sram_track_scheduler.sv
// Bench for sram_track_scheduler: async SRAM model plus a per-tick reference of addresses, samples and offset.
module tb_sram_track_scheduler;
    import sram_sched_pkg::*;

`ifdef RECORD_EN
    localparam bit REC = 1'b1;
`else
    localparam bit REC = 1'b0;
`endif
    localparam logic [16:0] MAX_OFF = 17'h1FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  en = '0;
    logic        restart = 1'b0;
    logic        wr_req = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_ack, valid, wrap, ovr, busy;
    logic [63:0] samples;
    logic [16:0] offset;
    logic [19:0] addr;
    logic        we_n, ce_n, oe_n, lb_n, ub_n;
    wire  [15:0] dq;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [16:0] m_off = '0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [19:0] a);
        logic [3:0] hi;
        hi = a[19:16];
        return a[15:0] ^ {hi, hi, hi, hi};
    endfunction

    assign dq = (!oe_n && we_n) ? mem_val(addr) : 'z;

    sram_track_scheduler dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_track_en(en),
        .i_restart(restart), .i_wr_req(wr_req), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
        .o_samples(samples), .o_sample_valid(valid), .o_offset(offset), .o_wrap(wrap),
        .o_overrun(ovr), .o_busy(busy), .o_SRAM_ADDR(addr), .io_SRAM_DQ(dq),
        .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
        .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_offset(input logic [16:0] v);
        force dut.r_offset = v;
        step();
        release dut.r_offset;
        m_off = v;
        chk("preset offset", 64'(offset), 64'(v));
    endtask

    task automatic run_seq(input logic [3:0] s_en, input bit s_wr, input logic [15:0] s_d,
                           input bit rs_mid, input bit tk_mid, input string tag);
        int          e, exp_lat, lat, nvalid, nwe, nack, novr;
        bit          serv, exp_wrap;
        logic [19:0] exp_q[$];
        logic [19:0] rd_q[$];
        logic [19:0] a, waddr;
        logic [15:0] wdata;
        logic        woe;
        logic [63:0] exp_samp, got_samp;
        logic [16:0] exp_off, got_off;
        logic        got_wrap;

        serv     = REC && s_wr;
        e        = $countones(s_en);
        exp_lat  = 2*e + 1 + (serv ? 2 : 0);
        exp_samp = '0;
        for (int t = 0; t < 4; t++) begin
            a = 20'(((t + 1) << 17) | int'(m_off));
            if (s_en[t]) begin
                exp_q.push_back(a);
                exp_samp[t*16 +: 16] = mem_val(a);
            end
        end
        if (rs_mid) begin
            exp_off = '0; exp_wrap = 1'b0;
        end else if (m_off == MAX_OFF) begin
            exp_off = '0; exp_wrap = 1'b1;
        end else begin
            exp_off = m_off + 17'd1; exp_wrap = 1'b0;
        end

        lat = -1; nvalid = 0; nwe = 0; nack = 0; novr = 0;
        waddr = '0; wdata = '0; woe = 1'b0; got_samp = '0; got_off = '0; got_wrap = 1'b0;
        en = s_en; wr_req = s_wr; wr_data = s_d; tick = 1'b1;
        step();
        tick = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (n < 2*e && (rd_q.size() == 0 || rd_q[rd_q.size()-1] != addr)) rd_q.push_back(addr);
            if (!we_n) begin
                nwe++; waddr = addr; wdata = dq; woe = oe_n;
            end
            if (wr_ack) nack++;
            if (ovr) novr++;
            if (valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat = n; got_samp = samples; got_off = offset; got_wrap = wrap;
                end
            end
            tick    = tk_mid && (n == 2);
            restart = rs_mid && (n == 1);
            if (lat >= 0 && n >= lat + 10) break;
            step();
        end
        tick = 1'b0; restart = 1'b0; wr_req = 1'b0;

        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " valid count"}, 64'(nvalid), 64'd1);
        chk({tag, " read count"}, 64'(rd_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++)
            chk({tag, " read addr"}, 64'(rd_q[i]), 64'(exp_q[i]));
        chk({tag, " samples"}, got_samp, exp_samp);
        chk({tag, " offset"}, 64'(got_off), 64'(exp_off));
        chk({tag, " wrap"}, 64'(got_wrap), 64'(exp_wrap));
        chk({tag, " we pulses"}, 64'(nwe), serv ? 64'd1 : 64'd0);
        chk({tag, " ack pulses"}, 64'(nack), serv ? 64'd1 : 64'd0);
        chk({tag, " overrun"}, 64'(novr), tk_mid ? 64'd1 : 64'd0);
        if (serv) begin
            chk({tag, " write addr"}, 64'(waddr), 64'(m_off));
            chk({tag, " write data"}, 64'(wdata), 64'(s_d));
            chk({tag, " oe_n in write"}, 64'(woe), 64'd1);
        end
        chk({tag, " idle after"}, 64'(busy), 64'd0);
        m_off = exp_off;
    endtask

    initial begin
        int          e;
        logic [3:0]  r_en;
        bit          found;

        step();
        step();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset addr", 64'(addr), 64'd0);
        chk("reset we_n", 64'(we_n), 64'd1);
        chk("reset oe_n", 64'(oe_n), 64'd0);
        chk("reset ce/lb/ub", 64'({ce_n, lb_n, ub_n}), 64'd0);
        chk("reset samples", samples, 64'd0);
        chk("reset pulses", 64'({valid, wrap, ovr, wr_ack}), 64'd0);
        chk("reset offset", 64'(offset), 64'd0);
        rst_n = 1'b1;
        step();

        run_seq(4'b1111, 1'b0, 16'h0000, 1'b0, 1'b0, "all tracks");
        run_seq(4'b0101, 1'b0, 16'h0000, 1'b0, 1'b0, "tracks 0,2");
        set_offset(17'h00010);
        run_seq(4'b1111, 1'b1, 16'hBEEF, 1'b0, 1'b0, "record");
        set_offset(MAX_OFF);
        run_seq(4'b1111, 1'b0, 16'h0000, 1'b0, 1'b0, "wrap");
        run_seq(4'b0001, 1'b0, 16'h0000, 1'b0, 1'b0, "after wrap");
        run_seq(4'b1111, 1'b0, 16'h0000, 1'b0, 1'b1, "overrun");
        run_seq(4'b0110, 1'b1, 16'h1234, 1'b1, 1'b0, "busy restart");
        run_seq(4'b0000, 1'b1, 16'h5A5A, 1'b0, 1'b0, "no tracks");

        set_offset(17'h00005);
        restart = 1'b1;
        step();
        restart = 1'b0;
        m_off = '0;
        chk("idle restart offset", 64'(offset), 64'd0);

        for (int i = 0; i < 25; i++) begin
            r_en = 4'($urandom);
            e = $countones(r_en);
            run_seq(r_en, 1'($urandom_range(0, 1)), 16'($urandom),
                    (e >= 1) && ($urandom_range(0, 3) == 0),
                    (e >= 2) && ($urandom_range(0, 3) == 0), "random");
        end

        en = 4'b1111; wr_req = 1'b1; wr_data = 16'hC0DE; tick = 1'b1;
        step();
        tick = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (REC ? !we_n : (n == 3)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("mid-seq point reached", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset we_n", 64'(we_n), 64'd1);
        chk("async reset busy", 64'(busy), 64'd0);
        chk("async reset ack", 64'(wr_ack), 64'd0);
        wr_req = 1'b0;
        step();
        rst_n = 1'b1;
        m_off = '0;
        step();
        run_seq(4'b1000, 1'b0, 16'h0000, 1'b0, 1'b0, "post reset");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
